stress_stimulus_gen: RTL
========================

STRESS_STIMULUS_GEN -- requirements
Module: stress_stimulus_gen

Interface
REQ-001 Parameter: DEPTH, 8, pattern FIFO entries (power of 2, 2..16).
REQ-002 Parameter: HOLD_W, 4, width of per-step hold count.
REQ-003 Port: clk  input  1  sole clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: wr_valid  input  1  pattern-step write request.
REQ-006 Port: wr_ready  output  1  FIFO can accept a step (not full).
REQ-007 Port: wr_pattern  input  3  sensor levels {s3,s2,s1} for the step.
REQ-008 Port: wr_hold  input  HOLD_W  step duration minus one, in cycles.
REQ-009 Port: start  input  1  single-cycle pulse to begin playback.
REQ-010 Port: sensor  output  3  driven sensor lines; bit0=sensor1, bit1=sensor2, bit2=sensor3.
REQ-011 Port: response  input  1  response line returned from the stress sensor under test.
REQ-012 Port: busy  output  1  high while playing.
REQ-013 Port: done  output  1  one-cycle pulse when playback completes.
REQ-014 Port: resp_count  output  8  count of response rising edges during the last playback.

Function
REQ-015 Write accepted when wr_valid && wr_ready on a clock edge; {wr_pattern,wr_hold} pushed to FIFO tail.
REQ-016 wr_ready = 0 when FIFO holds DEPTH entries, else 1; writes permitted in both IDLE and PLAY.
REQ-017 States: IDLE, LOAD, PLAY, FINISH.
REQ-018 IDLE: sensor = 3'b000, busy = 0; start with FIFO non-empty -> LOAD; start with FIFO empty -> FINISH (done pulses, resp_count = 0).
REQ-019 LOAD (1 cycle): pop head, register pattern to sensor, load hold counter with wr_hold value -> PLAY; busy = 1.
REQ-020 PLAY: sensor held constant; hold counter decrements each cycle; step lasts exactly hold+1 cycles of sensor output.
REQ-021 PLAY, counter = 0: FIFO non-empty -> pop next step, update sensor on the next cycle with no gap (stay PLAY); FIFO empty -> FINISH.
REQ-022 FINISH (1 cycle): sensor = 3'b000, done = 1, busy = 0 -> IDLE.
REQ-023 start ignored outside IDLE.
REQ-024 Simultaneous push and pop on the same edge when full: pop occurs, push accepted only if wr_ready was 1 in that cycle (no overflow).
REQ-025 response passed through a 2-flop synchronizer; rising edge = sync value 1, previous 0.
REQ-026 resp_count cleared on the LOAD entry from IDLE, increments per rising edge while busy, saturates at 255, holds value in IDLE.
REQ-027 FIFO pointers wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, FIFO empty, sensor = 0, busy = 0, done = 0, wr_ready = 1, resp_count = 0, synchronizer flops = 0.
REQ-029 Reset mid-playback discards all queued steps; no done pulse generated.
REQ-030 Deassertion takes effect on the next rising clk; first write accepted on the first edge after release.

Configuration
REQ-031 Macro STRESS_RESP_CAPTURE_EN defined: synchronizer and resp_count logic per REQ-025/026.
REQ-032 Macro STRESS_RESP_CAPTURE_EN undefined: synchronizer and counter removed, resp_count tied 8'd0, response unused; all other behaviour identical.

Verification
REQ-033 Write steps (3'b001,hold 2),(3'b110,hold 0); pulse start -> sensor 001 for 3 cycles, then 110 for 1 cycle, then 000 with done high one cycle, busy high across both steps.
REQ-034 Write 8 steps with DEPTH=8 -> wr_ready 0 after 8th accept; 9th wr_valid held is not accepted until playback pops one entry.
REQ-035 Start with empty FIFO -> done pulse one cycle after start, sensor stays 000, resp_count 0.
REQ-036 Playback of step (3'b111,hold 15) while toggling response 0->1 five times -> resp_count = 5 after done (macro defined); resp_count = 0 (macro undefined).
REQ-037 Assert rst_n low during second of three steps -> sensor 000, busy 0 immediately, no done; after release a new start with empty FIFO yields done only.
REQ-038 Write one step during PLAY before the last step ends -> played contiguously, no extra 000 cycle between steps.

Source files
------------

// File: rtl/stress_stimulus_gen.sv
// -----------------------------------------------------------------------------
// stress_stimulus_gen
//
// Plays a queued sequence of sensor-level steps onto three sensor lines and
// counts rising edges seen on the response line of the sensor under test.
// Each step is {pattern, hold}. Its pattern is driven for hold+1 cycles.
// Consecutive steps follow each other with no idle gap.
//
// Optional feature macro: STRESS_RESP_CAPTURE_EN
//   defined   : response is synchronized and its rising edges are counted
//   undefined : no capture logic, resp_count is tied to zero
//
// Parameters
//   DEPTH      pattern FIFO entries (power of 2, 2..16)
//   HOLD_W     width of the per-step hold count
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr_valid   step write request
//   wr_ready   FIFO not full
//   wr_pattern {s3,s2,s1} levels for the step
//   wr_hold    step duration minus one, in cycles
//   start      single-cycle pulse that begins playback (IDLE only)
//   sensor     driven sensor lines (bit0 = sensor1)
//   response   response line from the sensor under test (asynchronous)
//   busy       high while a playback is in progress
//   done       one-cycle pulse at the end of playback
//   resp_count response rising edges counted during the last playback
//
// Write handshake: a step is accepted on any rising edge where
// wr_valid && wr_ready. wr_ready depends only on registered occupancy.
// -----------------------------------------------------------------------------
module stress_stimulus_gen #(
   parameter int DEPTH  = 8,
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [2:0]        wr_pattern,
   input  logic [HOLD_W-1:0] wr_hold,
   input  logic              start,
   output logic [2:0]        sensor,
   input  logic              response,
   output logic              busy,
   output logic              done,
   output logic [7:0]        resp_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 3 + HOLD_W;

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, FINISH} state_t;

   state_t            state;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic [HOLD_W-1:0] hold_cnt;
   logic [ENT_W-1:0]  head;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   assign wr_ready   = (fifo_count != CNT_W'(DEPTH));
   assign fifo_empty = (fifo_count == '0);
   assign push       = wr_valid && wr_ready;
   assign head       = mem[rd_ptr];

   // The FSM consumes the head entry in LOAD and whenever the current step
   // expires in PLAY with another step already queued.
   assign pop = (state == LOAD) ||
                ((state == PLAY) && (hold_cnt == '0) && !fifo_empty);

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {wr_pattern, wr_hold};
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two. A push on a full
   // FIFO is impossible because wr_ready gates it in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sensor   <= 3'b000;
         busy     <= 1'b0;
         done     <= 1'b0;
         hold_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               sensor <= 3'b000;
               busy   <= 1'b0;
               if (start) begin
                  if (!fifo_empty) begin
                     state <= LOAD;
                     busy  <= 1'b1;
                  end else begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end
               end
            end
            LOAD: begin
               sensor   <= head[HOLD_W +: 3];
               hold_cnt <= head[HOLD_W-1:0];
               state    <= PLAY;
            end
            PLAY: begin
               if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end else if (!fifo_empty) begin
                  // Next step takes over on the following cycle: no gap.
                  sensor   <= head[HOLD_W +: 3];
                  hold_cnt <= head[HOLD_W-1:0];
               end else begin
                  state  <= FINISH;
                  sensor <= 3'b000;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------- response capture
`ifdef STRESS_RESP_CAPTURE_EN
   logic       resp_sync1;
   logic       resp_sync2;
   logic       resp_prev;
   logic [7:0] resp_cnt_q;
   logic       resp_rise;
   logic       resp_clear;

   assign resp_rise  = resp_sync2 && !resp_prev;
   // Cleared whenever a start is honoured, including an empty-FIFO start.
   assign resp_clear = (state == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_sync1 <= 1'b0;
         resp_sync2 <= 1'b0;
         resp_prev  <= 1'b0;
         resp_cnt_q <= 8'd0;
      end else begin
         resp_sync1 <= response;
         resp_sync2 <= resp_sync1;
         resp_prev  <= resp_sync2;
         if (resp_clear) begin
            resp_cnt_q <= 8'd0;
         end else if (busy && resp_rise && (resp_cnt_q != 8'hFF)) begin
            resp_cnt_q <= resp_cnt_q + 8'd1;
         end
      end
   end

   assign resp_count = resp_cnt_q;
`else
   logic unused_response;
   assign unused_response = response;
   assign resp_count      = 8'd0;
`endif

endmodule
